// File: rtl/ic_axi_pkg.sv
// Shared constants for the AXI4-Lite to SRAM bridge.
// AXI response codes and the bridge FSM state encoding.
package ic_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WR_COLLECT = 3'd1;
  localparam logic [2:0] ST_WR_MEM     = 3'd2;
  localparam logic [2:0] ST_WR_RSP     = 3'd3;
  localparam logic [2:0] ST_RD_MEM     = 3'd4;
  localparam logic [2:0] ST_RD_WAIT    = 3'd5;
  localparam logic [2:0] ST_RD_RSP     = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE       = ST_IDLE,
    S_WR_COLLECT = ST_WR_COLLECT,
    S_WR_MEM     = ST_WR_MEM,
    S_WR_RSP     = ST_WR_RSP,
    S_RD_MEM     = ST_RD_MEM,
    S_RD_WAIT    = ST_RD_WAIT,
    S_RD_RSP     = ST_RD_RSP
  } state_e;

endpackage

// File: rtl/ic_axi_sram_bridge_if.sv
// AXI4-Lite bus bundle between the CPU-side bridge and the SRAM bridge.
// slave: the SRAM bridge; master: the bus driver (CPU bridge or bench).
interface ic_axi_sram_bridge_if;

  logic        s0_awvalid;
  logic        s0_awready;
  logic [31:0] s0_awaddr;
  logic [2:0]  s0_awprot;
  logic        s0_wvalid;
  logic        s0_wready;
  logic [31:0] s0_wdata;
  logic [3:0]  s0_wstrb;
  logic        s0_bvalid;
  logic        s0_bready;
  logic [1:0]  s0_bresp;
  logic        s0_arvalid;
  logic        s0_arready;
  logic [31:0] s0_araddr;
  logic [2:0]  s0_arprot;
  logic        s0_rvalid;
  logic        s0_rready;
  logic [1:0]  s0_rresp;
  logic [31:0] s0_rdata;

  modport slave (
    input  s0_awvalid, s0_awaddr, s0_awprot,
    input  s0_wvalid, s0_wdata, s0_wstrb,
    input  s0_bready,
    input  s0_arvalid, s0_araddr, s0_arprot,
    input  s0_rready,
    output s0_awready, s0_wready,
    output s0_bvalid, s0_bresp,
    output s0_arready,
    output s0_rvalid, s0_rresp, s0_rdata
  );

  modport master (
    output s0_awvalid, s0_awaddr, s0_awprot,
    output s0_wvalid, s0_wdata, s0_wstrb,
    output s0_bready,
    output s0_arvalid, s0_araddr, s0_arprot,
    output s0_rready,
    input  s0_awready, s0_wready,
    input  s0_bvalid, s0_bresp,
    input  s0_arready,
    input  s0_rvalid, s0_rresp, s0_rdata
  );

endinterface

// File: rtl/ic_axi_sram_bridge.sv
// AXI4-Lite slave driving a 1-cycle-latency word SRAM, one txn at a time.
// Ports: s0_aclk/s0_aresetn, s0 (AXI slave modport), sram_* SRAM side.
module ic_axi_sram_bridge
  import ic_axi_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE       = 32'h0000_0000
) (
  input  logic                  s0_aclk,
  input  logic                  s0_aresetn,
  ic_axi_sram_bridge_if.slave   s0,
  output logic                  sram_cen,
  output logic [3:0]            sram_wstrb,
  output logic [DEPTH_LOG2-1:0] sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  localparam int HI = DEPTH_LOG2 + 2;

  function automatic logic in_rng(input logic [31:0] a);
    return a[31:HI] == BASE[31:HI];
  endfunction

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_got_q, aw_got_d;
  logic        w_got_q, w_got_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        prio_q, prio_d;
  logic        alive_q;

  logic aw_rdy, w_rdy, ar_rdy;
  logic wr_req, rd_gnt, wr_gnt;
  logic wr_en, rd_en;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    aw_got_d = aw_got_q;
    w_got_d  = w_got_q;
    bresp_d  = bresp_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    prio_d   = prio_q;
    aw_rdy   = 1'b0;
    w_rdy    = 1'b0;
    ar_rdy   = 1'b0;
    wr_req   = s0.s0_awvalid | s0.s0_wvalid;
    rd_gnt   = alive_q & s0.s0_arvalid
             & (~wr_req | prio_q);
    wr_gnt   = alive_q & wr_req & ~rd_gnt;
    unique case (state_q)
      S_IDLE: begin
        ar_rdy = rd_gnt;
        aw_rdy = wr_gnt;
        w_rdy  = wr_gnt;
        if (rd_gnt) begin
          addr_d  = s0.s0_araddr;
          state_d = S_RD_MEM;
        end else if (wr_gnt) begin
          if (s0.s0_awvalid) addr_d = s0.s0_awaddr;
          if (s0.s0_wvalid) begin
            wdata_d = s0.s0_wdata;
            wstrb_d = s0.s0_wstrb;
          end
          aw_got_d = s0.s0_awvalid;
          w_got_d  = s0.s0_wvalid;
          state_d  = (s0.s0_awvalid && s0.s0_wvalid)
                   ? S_WR_MEM : S_WR_COLLECT;
        end
      end
      S_WR_COLLECT: begin
        // only the still-missing channel is offered ready
        aw_rdy = alive_q & ~aw_got_q;
        w_rdy  = alive_q & ~w_got_q;
        if (aw_rdy && s0.s0_awvalid) begin
          addr_d   = s0.s0_awaddr;
          aw_got_d = 1'b1;
        end
        if (w_rdy && s0.s0_wvalid) begin
          wdata_d = s0.s0_wdata;
          wstrb_d = s0.s0_wstrb;
          w_got_d = 1'b1;
        end
        if (aw_got_d && w_got_d) state_d = S_WR_MEM;
      end
      S_WR_MEM: begin
        bresp_d = in_rng(addr_q) ? AXI_RESP_OKAY
                                 : AXI_RESP_SLVERR;
        state_d = S_WR_RSP;
      end
      S_WR_RSP: begin
        if (s0.s0_bready) begin
          prio_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RD_MEM: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        rdata_d = in_rng(addr_q) ? sram_rdata : '0;
        rresp_d = in_rng(addr_q) ? AXI_RESP_OKAY
                                 : AXI_RESP_SLVERR;
        state_d = S_RD_RSP;
      end
      S_RD_RSP: begin
        if (s0.s0_rready) begin
          prio_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge s0_aclk or negedge s0_aresetn) begin
    if (!s0_aresetn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      bresp_q  <= '0;
      rresp_q  <= '0;
      rdata_q  <= '0;
      prio_q   <= 1'b0;
      alive_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      aw_got_q <= aw_got_d;
      w_got_q  <= w_got_d;
      bresp_q  <= bresp_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
      prio_q   <= prio_d;
      alive_q  <= 1'b1;
    end
  end

  assign s0.s0_awready = aw_rdy;
  assign s0.s0_wready  = w_rdy;
  assign s0.s0_arready = ar_rdy;
  assign s0.s0_bvalid  = (state_q == S_WR_RSP);
  assign s0.s0_bresp   = bresp_q;
  assign s0.s0_rvalid  = (state_q == S_RD_RSP);
  assign s0.s0_rresp   = rresp_q;
  assign s0.s0_rdata   = rdata_q;

  // SRAM side depends on registered state only
  assign wr_en = (state_q == S_WR_MEM) & in_rng(addr_q)
               & (|wstrb_q);
  assign rd_en = (state_q == S_RD_MEM) & in_rng(addr_q);

  assign sram_cen   = wr_en | rd_en;
  assign sram_wstrb = wr_en ? wstrb_q : 4'h0;
  assign sram_addr  = addr_q[HI-1:2];
  assign sram_wdata = wdata_q;

  logic unused_ok;
  assign unused_ok = ^{s0.s0_awprot, s0.s0_arprot,
                       addr_q[1:0]};

endmodule

// File: tb/tb_ic_axi_sram_bridge.sv
// Directed bench for ic_axi_sram_bridge with an SRAM model.
// Expected responses are queued at issue and checked on output.
module tb_ic_axi_sram_bridge;
  import ic_axi_pkg::*;

  localparam int          DL   = 10;
  localparam logic [31:0] BASE = 32'h0000_0000;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ic_axi_sram_bridge_if s0();

  logic          sram_cen;
  logic [3:0]    sram_wstrb;
  logic [DL-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata = '0;

  ic_axi_sram_bridge #(.DEPTH_LOG2(DL), .BASE(BASE)) dut (
    .s0_aclk    (clk),
    .s0_aresetn (rst_n),
    .s0         (s0),
    .sram_cen   (sram_cen),
    .sram_wstrb (sram_wstrb),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  logic [31:0] mem [0:(1<<DL)-1];
  int cen_cnt = 0;

  always @(posedge clk) begin
    if (sram_cen) begin
      cen_cnt++;
      if (sram_wstrb == 4'h0) sram_rdata <= mem[sram_addr];
      else
        for (int b = 0; b < 4; b++)
          if (sram_wstrb[b])
            mem[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
    end
  end

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   gq[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    return a[31:DL+2] == BASE[31:DL+2];
  endfunction

  task automatic do_write(input logic [31:0] a,
                          input logic [31:0] d,
                          input logic [3:0]  s,
                          input int          w_lead,
                          input int          bdly);
    exp_t e;
    logic inr, awd, wd, acc;
    int n, c0;
    logic [1:0] r0;
    inr = in_rng(a);
    acc = inr && (s != 4'h0);
    e.resp = inr ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    e.data = '0;
    sb.push_back(e);
    s0.s0_awaddr  = a;
    s0.s0_wdata   = d;
    s0.s0_wstrb   = s;
    s0.s0_wvalid  = 1'b1;
    s0.s0_awvalid = (w_lead == 0);
    s0.s0_bready  = (bdly == 0);
    awd = 1'b0;
    wd  = 1'b0;
    n   = 0;
    while (!(awd && wd) && n < 40) begin
      @(negedge clk);
      if (w_lead > 0 && n == 1) begin
        chk("wr_collect_wready", 32'(s0.s0_wready), 32'd0);
        chk("wr_collect_awready", 32'(s0.s0_awready), 32'd1);
      end
      if (s0.s0_awvalid && s0.s0_awready) awd = 1'b1;
      if (s0.s0_wvalid && s0.s0_wready) wd = 1'b1;
      @(posedge clk); #1;
      n++;
      if (awd) s0.s0_awvalid = 1'b0;
      if (wd) s0.s0_wvalid = 1'b0;
      if (!awd && n >= w_lead) s0.s0_awvalid = 1'b1;
    end
    s0.s0_awvalid = 1'b0;
    s0.s0_wvalid  = 1'b0;
    chk("wr_handshake", 32'(awd && wd), 32'd1);
    c0 = cen_cnt;
    @(negedge clk);
    chk("wr_sram_cen", 32'(sram_cen), 32'(acc));
    if (acc) begin
      chk("wr_sram_wstrb", 32'(sram_wstrb), 32'(s));
      chk("wr_sram_addr", 32'(sram_addr), 32'(a[DL+1:2]));
      chk("wr_sram_wdata", sram_wdata, d);
    end
    n = 1;
    while (!s0.s0_bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wr_bvalid_latency", 32'(n), 32'd2);
    chk("wr_sb_size", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    chk("wr_bresp", 32'(s0.s0_bresp), 32'(e.resp));
    r0 = s0.s0_bresp;
    for (int k = 0; k < bdly; k++) begin
      @(negedge clk);
      chk("wr_bvalid_hold", 32'(s0.s0_bvalid), 32'd1);
      chk("wr_bresp_hold", 32'(s0.s0_bresp), 32'(r0));
    end
    if (bdly > 0) begin
      @(posedge clk); #1;
      s0.s0_bready = 1'b1;
    end
    @(posedge clk); #1;
    s0.s0_bready = 1'b0;
    chk("wr_bvalid_drop", 32'(s0.s0_bvalid), 32'd0);
    chk("wr_sram_count", 32'(cen_cnt - c0), 32'(acc));
  endtask

  task automatic do_read(input logic [31:0] a,
                         input logic [31:0] d,
                         input int          rdly);
    exp_t e;
    logic inr, got;
    int n, c0;
    logic [31:0] d0;
    logic [1:0]  r0;
    inr = in_rng(a);
    e.resp = inr ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    e.data = inr ? d : '0;
    sb.push_back(e);
    s0.s0_araddr  = a;
    s0.s0_arvalid = 1'b1;
    s0.s0_rready  = (rdly == 0);
    got = 1'b0;
    n   = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      if (s0.s0_arvalid && s0.s0_arready) got = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    s0.s0_arvalid = 1'b0;
    chk("rd_handshake", 32'(got), 32'd1);
    c0 = cen_cnt;
    @(negedge clk);
    chk("rd_sram_cen", 32'(sram_cen), 32'(inr));
    chk("rd_sram_wstrb", 32'(sram_wstrb), 32'd0);
    if (inr) chk("rd_sram_addr", 32'(sram_addr), 32'(a[DL+1:2]));
    n = 1;
    while (!s0.s0_rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rd_rvalid_latency", 32'(n), 32'd3);
    chk("rd_sb_size", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    chk("rd_rresp", 32'(s0.s0_rresp), 32'(e.resp));
    chk("rd_rdata", s0.s0_rdata, e.data);
    r0 = s0.s0_rresp;
    d0 = s0.s0_rdata;
    for (int k = 0; k < rdly; k++) begin
      @(negedge clk);
      chk("rd_rvalid_hold", 32'(s0.s0_rvalid), 32'd1);
      chk("rd_rresp_hold", 32'(s0.s0_rresp), 32'(r0));
      chk("rd_rdata_hold", s0.s0_rdata, d0);
    end
    if (rdly > 0) begin
      @(posedge clk); #1;
      s0.s0_rready = 1'b1;
    end
    @(posedge clk); #1;
    s0.s0_rready = 1'b0;
    chk("rd_rvalid_drop", 32'(s0.s0_rvalid), 32'd0);
    chk("rd_sram_count", 32'(cen_cnt - c0), 32'(inr));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_awready"}, 32'(s0.s0_awready), 32'd0);
    chk({tag, "_wready"}, 32'(s0.s0_wready), 32'd0);
    chk({tag, "_arready"}, 32'(s0.s0_arready), 32'd0);
    chk({tag, "_bvalid"}, 32'(s0.s0_bvalid), 32'd0);
    chk({tag, "_rvalid"}, 32'(s0.s0_rvalid), 32'd0);
    chk({tag, "_bresp"}, 32'(s0.s0_bresp), 32'd0);
    chk({tag, "_rresp"}, 32'(s0.s0_rresp), 32'd0);
    chk({tag, "_rdata"}, s0.s0_rdata, 32'd0);
    chk({tag, "_cen"}, 32'(sram_cen), 32'd0);
    chk({tag, "_wstrb"}, 32'(sram_wstrb), 32'd0);
    chk({tag, "_addr"}, 32'(sram_addr), 32'd0);
    chk({tag, "_wdata"}, sram_wdata, 32'd0);
  endtask

  initial begin
    int n, ng, nr, nb, g;
    logic got;

    // valids held high straight out of reset
    s0.s0_awaddr  = 32'h20;
    s0.s0_awprot  = 3'b0;
    s0.s0_wdata   = 32'hA5A5_0F0F;
    s0.s0_wstrb   = 4'hF;
    s0.s0_araddr  = 32'h20;
    s0.s0_arprot  = 3'b0;
    s0.s0_awvalid = 1'b1;
    s0.s0_wvalid  = 1'b1;
    s0.s0_arvalid = 1'b1;
    s0.s0_bready  = 1'b1;
    s0.s0_rready  = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("alive_gate_aw", 32'(s0.s0_awready), 32'd0);
    chk("alive_gate_ar", 32'(s0.s0_arready), 32'd0);

    gq.push_back(0);
    gq.push_back(1);
    gq.push_back(0);
    gq.push_back(1);
    n = 0; ng = 0; nr = 0; nb = 0;
    while (ng < 4 && n < 80) begin
      @(negedge clk);
      n++;
      if (s0.s0_rvalid) begin
        nr++;
        chk("alt_rdata", s0.s0_rdata, 32'hA5A5_0F0F);
        chk("alt_rresp", 32'(s0.s0_rresp), 32'(AXI_RESP_OKAY));
      end
      if (s0.s0_bvalid) nb++;
      if (s0.s0_awready || s0.s0_arready) begin
        chk("alt_excl", 32'(s0.s0_awready && s0.s0_arready),
            32'd0);
        g = s0.s0_arready ? 1 : 0;
        chk("alt_grant", 32'(g), 32'(gq.pop_front()));
        ng++;
      end
    end
    chk("alt_grants", 32'(ng), 32'd4);
    @(posedge clk); #1;
    s0.s0_awvalid = 1'b0;
    s0.s0_wvalid  = 1'b0;
    s0.s0_arvalid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (s0.s0_rvalid) begin
        nr++;
        chk("alt_rdata", s0.s0_rdata, 32'hA5A5_0F0F);
      end
      if (s0.s0_bvalid) nb++;
    end
    chk("alt_rsp_rd", 32'(nr), 32'd2);
    chk("alt_rsp_wr", 32'(nb), 32'd2);
    @(posedge clk); #1;
    s0.s0_bready = 1'b0;
    s0.s0_rready = 1'b0;

    // aligned full write then read back
    do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
    do_read(32'h10, 32'hDEAD_BEEF, 0);
    // W two cycles ahead of AW, byte 1 only
    do_write(32'h10, 32'h1122_3344, 4'b0010, 2, 0);
    do_read(32'h10, 32'hDEAD_33EF, 0);
    // just past the window
    do_read(32'h1000, 32'h0, 0);
    do_write(32'h1000, 32'h1234_5678, 4'hF, 0, 0);
    // zero strobe in range: OKAY, no access
    do_write(32'h10, 32'hFFFF_FFFF, 4'h0, 0, 0);
    do_read(32'h10, 32'hDEAD_33EF, 0);
    // response back-pressure
    do_read(32'h10, 32'hDEAD_33EF, 5);
    do_write(32'h1004, 32'h0BAD_0BAD, 4'hF, 0, 5);

    // reset while the read sits in RD_WAIT
    s0.s0_araddr  = 32'h10;
    s0.s0_arvalid = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      if (s0.s0_arready) got = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    s0.s0_arvalid = 1'b0;
    chk("mid_handshake", 32'(got), 32'd1);
    @(negedge clk);
    chk("mid_rd_mem_cen", 32'(sram_cen), 32'd1);
    @(posedge clk); #1;
    s0.s0_arvalid = 1'b1;
    s0.s0_awvalid = 1'b1;
    s0.s0_wvalid  = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_alive_aw", 32'(s0.s0_awready), 32'd0);
    chk("mid_alive_w", 32'(s0.s0_wready), 32'd0);
    chk("mid_alive_ar", 32'(s0.s0_arready), 32'd0);
    @(posedge clk); #1;
    chk("mid_prio_aw", 32'(s0.s0_awready), 32'd1);
    chk("mid_prio_ar", 32'(s0.s0_arready), 32'd0);
    s0.s0_arvalid = 1'b0;
    s0.s0_awvalid = 1'b0;
    s0.s0_wvalid  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("mid_no_rvalid", 32'(s0.s0_rvalid), 32'd0);
      chk("mid_no_bvalid", 32'(s0.s0_bvalid), 32'd0);
    end
    do_read(32'h10, 32'hDEAD_33EF, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
